// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared constants and FSM state encoding for the data-RAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  // Largest supported number of requesting cores
  localparam int MAX_CORES     = 8;

  // Default bus geometry of the shared data RAM
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 1024;

  // Arbiter state encoding: IDLE -> ACCESS -> HOLD -> RESP -> IDLE
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Searches from last_grant+1
//            (mod N) for the first core that is both requesting and eligible.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     elig_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan offsets from farthest to nearest so the nearest candidate is written last and wins
  always_comb begin
    logic [IDX_W-1:0] cand;
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((32'(last_i) + 32'(k)) % 32'(N));
      if (req_i[cand] && elig_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing one single-port data RAM between
//            NUM_CORES cores. Each access takes IDLE/ACCESS/HOLD/RESP.
//            Optional macro DMEM_ARB_LOCK_EN adds a lock port that lets one
//            core own the RAM across several accesses (atomic RMW).
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_CORES-1:0]        req_i,
  input  logic [NUM_CORES-1:0]        wr_i,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_CORES-1:0]        lock_i,
`endif
  output logic [NUM_CORES-1:0]        ack_o,
  output logic [NUM_CORES-1:0]        err_o,
  output logic [NUM_CORES*DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0]           ram_addr_o,
  output logic [DATA_W-1:0]           ram_din_o,
  output logic                        ram_wr_o,
  output logic                        ram_rd_o,
  input  logic [DATA_W-1:0]           ram_dout_i
);

  localparam int IDX_W = $clog2(NUM_CORES);
  // One extra bit so a depth equal to 2**ADDR_W is still representable
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   last_q;
  logic               wr_q;
  logic               oor_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q   [NUM_CORES];
  logic [ADDR_W-1:0]  addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]  wdata_arr [NUM_CORES];
  logic [NUM_CORES-1:0] elig;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               grant;

  // Per-core unpacking of the flat buses and per-core response decode
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign addr_arr[g]                 = addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g]                = wdata_i[g*DATA_W +: DATA_W];
    assign rdata_o[g*DATA_W +: DATA_W] = rdata_q[g];
    assign ack_o[g] = (state_q == ST_RESP) && (win_q == IDX_W'(g));
    assign err_o[g] = (state_q == ST_RESP) && (win_q == IDX_W'(g)) && oor_q;
  end

`ifdef DMEM_ARB_LOCK_EN
  logic             own_vld_q;
  logic [IDX_W-1:0] owner_q;
  logic             lock_q;

  // While a core owns the RAM it is the only eligible requester
  always_comb begin
    elig = {NUM_CORES{1'b1}};
    if (own_vld_q) elig = NUM_CORES'(1) << owner_q;
  end

  // Ownership is taken at a locked grant and released by the owner's next unlocked access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      own_vld_q <= 1'b0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
    end else if (grant) begin
      lock_q <= lock_i[pick_idx];
      if (lock_i[pick_idx]) begin
        own_vld_q <= 1'b1;
        owner_q   <= pick_idx;
      end
    end else if (state_q == ST_RESP && own_vld_q && !lock_q && win_q == owner_q) begin
      own_vld_q <= 1'b0;
    end
  end
`else
  assign elig = {NUM_CORES{1'b1}};
`endif

  rr_pick #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .elig_i  (elig),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  assign grant = (state_q == ST_IDLE) && pick_vld;

  // Fixed four-cycle sequence once a grant is made
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, winner and captured request fields; inputs are only sampled at grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      last_q  <= IDX_W'(NUM_CORES - 1);
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q   <= pick_idx;
        wr_q    <= wr_i[pick_idx];
        addr_q  <= addr_arr[pick_idx];
        wdata_q <= wdata_arr[pick_idx];
        oor_q   <= ({1'b0, addr_arr[pick_idx]} >= DEPTH_LIM);
      end
      if (state_q == ST_RESP) last_q <= win_q;
    end
  end

  // Read data lands in the winner's slot at the end of HOLD; out-of-range reads return zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CORES; i++) rdata_q[i] <= '0;
    end else if (state_q == ST_HOLD && !wr_q) begin
      rdata_q[win_q] <= oor_q ? '0 : ram_dout_i;
    end
  end

  // RAM controls decode purely from registered state; wr and rd are mutually exclusive by wr_q
  assign ram_addr_o = addr_q;
  assign ram_din_o  = wdata_q;
  assign ram_wr_o   = (state_q == ST_ACCESS) && wr_q && !oor_q;
  assign ram_rd_o   = ((state_q == ST_ACCESS) || (state_q == ST_HOLD)) && !wr_q && !oor_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter with a behavioural
//            1024x16 RAM. The lock scenario is built when DMEM_ARB_LOCK_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, wr, lock;
  logic [63:0] addr, wdata;
  logic [3:0]  ack, err;
  logic [63:0] rdata;
  logic [15:0] ram_addr, ram_din, ram_dout;
  logic        ram_wr, ram_rd;

  logic [15:0] mem [1024];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  int n_chk;
  int n_err;

  dmem_arbiter #(
    .NUM_CORES (4),
    .ADDR_W    (16),
    .DATA_W    (16),
    .MEM_DEPTH (1024)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .wr_i       (wr),
    .addr_i     (addr),
    .wdata_i    (wdata),
`ifdef DMEM_ARB_LOCK_EN
    .lock_i     (lock),
`endif
    .ack_o      (ack),
    .err_o      (err),
    .rdata_o    (rdata),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_wr_o   (ram_wr),
    .ram_rd_o   (ram_rd),
    .ram_dout_i (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a bench-side preload port
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wr) mem[ram_addr[9:0]] <= ram_din;
  end
  assign ram_dout = ram_rd ? mem[ram_addr[9:0]] : 16'h0000;

  function automatic logic [15:0] pre_val(input int i);
    return 16'h1100 + 16'(i) * 16'h0011;
  endfunction

  function automatic logic [15:0] rd_slot(input int i);
    return rdata[i*16 +: 16];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d, input logic l);
    req[i]           = r;
    wr[i]            = w;
    lock[i]          = l;
    addr[i*16 +: 16] = a;
    wdata[i*16 +: 16] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0;
    req = '0; wr = '0; lock = '0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    rst_n = 1'b0;

    // Preload mem[0..3] and mem[7] while reset is held
    for (int i = 0; i < 4; i++) begin
      pl_en = 1'b1; pl_addr = 10'(i); pl_data = pre_val(i);
      tick();
    end
    pl_addr = 10'd7; pl_data = 16'h0041;
    tick();
    pl_en = 1'b0;

    // Reset values
    check_eq("rst_ack",   64'(ack), 64'h0);
    check_eq("rst_err",   64'(err), 64'h0);
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_ctl",   64'({ram_wr, ram_rd}), 64'h0);
    check_eq("rst_bus",   64'({ram_addr, ram_din}), 64'h0);

    rst_n = 1'b1;
    tick();

    // Core 1 writes 0x00AB to address 5
    set_core(1, 1'b1, 1'b1, 16'd5, 16'h00AB, 1'b0);
    tick();
    check_eq("w_acc_wr",   64'(ram_wr), 64'h1);
    check_eq("w_acc_rd",   64'(ram_rd), 64'h0);
    check_eq("w_acc_addr", 64'(ram_addr), 64'd5);
    check_eq("w_acc_din",  64'(ram_din), 64'h00AB);
    check_eq("w_acc_ack",  64'(ack), 64'h0);
    tick();
    check_eq("w_hold_wr",  64'(ram_wr), 64'h0);
    check_eq("w_hold_ack", 64'(ack), 64'h0);
    check_eq("w_mem5",     64'(mem[5]), 64'h00AB);
    tick();
    check_eq("w_resp_ack", 64'(ack), 64'b0010);
    check_eq("w_resp_err", 64'(err), 64'h0);
    check_eq("w_resp_wr",  64'(ram_wr), 64'h0);
    // Same core presents a read of address 5
    set_core(1, 1'b1, 1'b0, 16'd5, 16'h0000, 1'b0);
    tick();
    check_eq("r_idle_ack", 64'(ack), 64'h0);
    tick();
    check_eq("r_acc_rd",   64'(ram_rd), 64'h1);
    check_eq("r_acc_wr",   64'(ram_wr), 64'h0);
    tick();
    check_eq("r_hold_rd",  64'(ram_rd), 64'h1);
    tick();
    check_eq("r_resp_ack", 64'(ack), 64'b0010);
    check_eq("r_rdata1",   64'(rd_slot(1)), 64'h00AB);
    set_core(1, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);

    // Fresh reset, then all four cores read simultaneously
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 16'(i), 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("rr_acc_addr%0d", i), 64'(ram_addr), 64'(i));
      check_eq($sformatf("rr_acc_ack%0d", i), 64'(ack), 64'h0);
      tick();
      check_eq($sformatf("rr_hold_ack%0d", i), 64'(ack), 64'h0);
      tick();
      check_eq($sformatf("rr_ack%0d", i), 64'(ack), 64'(4'b0001 << i));
      check_eq($sformatf("rr_rdata%0d", i), 64'(rd_slot(i)), 64'(pre_val(i)));
      set_core(i, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
      tick();
      check_eq($sformatf("rr_idle_ack%0d", i), 64'(ack), 64'h0);
    end

    // Core 2 reads out-of-range address 1024
    set_core(2, 1'b1, 1'b0, 16'd1024, 16'h0000, 1'b0);
    tick();
    check_eq("oor_acc_ctl",  64'({ram_wr, ram_rd}), 64'h0);
    tick();
    check_eq("oor_hold_ctl", 64'({ram_wr, ram_rd}), 64'h0);
    tick();
    check_eq("oor_ack",   64'(ack), 64'b0100);
    check_eq("oor_err",   64'(err), 64'b0100);
    check_eq("oor_rdata", 64'(rd_slot(2)), 64'h0);
    set_core(2, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    tick();

    // Core 3 read aborted by reset during HOLD
    set_core(3, 1'b1, 1'b0, 16'd5, 16'h0000, 1'b0);
    tick();
    tick();
    check_eq("ab_hold_rd", 64'(ram_rd), 64'h1);
    rst_n = 1'b0;
    #1;
    check_eq("ab_rst_ack",   64'(ack), 64'h0);
    check_eq("ab_rst_rdata", rdata, 64'h0);
    check_eq("ab_rst_ctl",   64'({ram_wr, ram_rd}), 64'h0);
    check_eq("ab_rst_bus",   64'({ram_addr, ram_din}), 64'h0);
    tick();
    check_eq("ab_rst_ack2",  64'(ack), 64'h0);
    set_core(0, 1'b1, 1'b0, 16'd0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("ab_first_addr", 64'(ram_addr), 64'd0);
    tick();
    tick();
    check_eq("ab_first_ack", 64'(ack), 64'b0001);
    set_core(0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check_eq("ab_core3_ack",   64'(ack), 64'b1000);
    check_eq("ab_core3_rdata", 64'(rd_slot(3)), 64'h00AB);
    set_core(3, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Locked read-modify-write of mem[7] by core 0 while core 1 waits
    set_core(0, 1'b1, 1'b0, 16'd7, 16'h0000, 1'b1);
    set_core(1, 1'b1, 1'b0, 16'd2, 16'h0000, 1'b0);
    tick();
    check_eq("lk_rd_addr", 64'(ram_addr), 64'd7);
    tick();
    tick();
    check_eq("lk_rd_ack",   64'(ack), 64'b0001);
    check_eq("lk_rd_rdata", 64'(rd_slot(0)), 64'h0041);
    set_core(0, 1'b1, 1'b1, 16'd7, rd_slot(0) + 16'h0001, 1'b0);
    tick();
    tick();
    check_eq("lk_wr_addr", 64'(ram_addr), 64'd7);
    check_eq("lk_wr_en",   64'(ram_wr), 64'h1);
    tick();
    tick();
    check_eq("lk_wr_ack", 64'(ack), 64'b0001);
    check_eq("lk_mem7",   64'(mem[7]), 64'h0042);
    set_core(0, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    tick();
    tick();
    check_eq("lk_c1_addr", 64'(ram_addr), 64'd2);
    tick();
    tick();
    check_eq("lk_c1_ack",   64'(ack), 64'b0010);
    check_eq("lk_c1_rdata", 64'(rd_slot(1)), 64'(pre_val(2)));
    check_eq("lk_mem7_end", 64'(mem[7]), 64'h0042);
    set_core(1, 1'b0, 1'b0, 16'd0, 16'h0000, 1'b0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
